// File: rtl/tea_pkg.sv
// Shared TEA definitions: key-schedule constant, default round count, FSM
// encoding and the initial decipher sum.
package tea_pkg;

  localparam int unsigned TEA_ROUNDS = 32;
  localparam logic [31:0] TEA_DELTA  = 32'h9E3779B9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } tea_state_e;

  // Decipher starts where encipher finished: delta * rounds, wrapped to 32 bits.
  function automatic logic [31:0] tea_init_sum(input logic [31:0] delta,
                                               input int unsigned rounds);
    return delta * 32'(rounds);
  endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One full TEA decipher round (both half-rounds), purely combinational.
// v1 is updated first and the new v1 feeds the v0 update.
module tea_dec_round (
  input  logic [31:0] v0_i,
  input  logic [31:0] v1_i,
  input  logic [31:0] sum_i,
  input  logic [31:0] k0_i,
  input  logic [31:0] k1_i,
  input  logic [31:0] k2_i,
  input  logic [31:0] k3_i,
  output logic [31:0] v0_o,
  output logic [31:0] v1_o
);

  logic [31:0] mix1;
  logic [31:0] v1_new;
  logic [31:0] mix0;

  assign mix1   = ((v0_i << 4) + k2_i) ^ (v0_i + sum_i) ^ ((v0_i >> 5) + k3_i);
  assign v1_new = v1_i - mix1;
  assign mix0   = ((v1_new << 4) + k0_i) ^ (v1_new + sum_i) ^ ((v1_new >> 5) + k1_i);

  assign v0_o = v0_i - mix0;
  assign v1_o = v1_new;

endmodule

// File: rtl/tea_decrypt_core.sv
// Iterative TEA decryption core: one round per clock through a single
// tea_dec_round instance, with valid/ready handshakes on both sides.
module tea_decrypt_core
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = TEA_ROUNDS,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_v0,
  input  logic [31:0]  in_v1,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_v0,
  output logic [31:0]  out_v1,
  output logic         busy,
  output tea_state_e   dbg_state_o
);

  localparam logic [31:0] SUM_INIT = tea_init_sum(DELTA, ROUNDS);
  localparam logic [5:0]  LAST_RND = 6'(ROUNDS - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Valid, once raised, holds with stable data until that edge;
  // ready never depends combinationally on the opposite side's signals.

  tea_state_e  state_q, state_d;
  logic [31:0] v0_q, v0_d;
  logic [31:0] v1_q, v1_d;
  logic [31:0] sum_q, sum_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] k0_q, k0_d;
  logic [31:0] k1_q, k1_d;
  logic [31:0] k2_q, k2_d;
  logic [31:0] k3_q, k3_d;
  logic [31:0] ov0_q, ov0_d;
  logic [31:0] ov1_q, ov1_d;

  logic        accept;
  logic        last_round;
  logic [31:0] rnd_v0;
  logic [31:0] rnd_v1;

  tea_dec_round u_round (
    .v0_i  (v0_q),
    .v1_i  (v1_q),
    .sum_i (sum_q),
    .k0_i  (k0_q),
    .k1_i  (k1_q),
    .k2_i  (k2_q),
    .k3_i  (k3_q),
    .v0_o  (rnd_v0),
    .v1_o  (rnd_v1)
  );

  assign accept     = in_valid && in_ready;
  assign last_round = (state_q == ST_ROUND) && (cnt_q == LAST_RND);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)     state_d = ST_ROUND;
      ST_ROUND: if (last_round) state_d = ST_DONE;
      ST_DONE:  if (out_ready)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = resetn && (state_q == ST_IDLE);
    out_valid   = (state_q == ST_DONE);
    busy        = (state_q == ST_ROUND) || (state_q == ST_DONE);
    dbg_state_o = state_q;
  end

  // Key words are captured only at accept so the block in flight ignores
  // later key changes; the output words live in their own registers so they
  // survive the next accept.
  always_comb begin
    v0_d  = v0_q;
    v1_d  = v1_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    k0_d  = k0_q;
    k1_d  = k1_q;
    k2_d  = k2_q;
    k3_d  = k3_q;
    ov0_d = ov0_q;
    ov1_d = ov1_q;
    if (accept) begin
      v0_d  = in_v0;
      v1_d  = in_v1;
      sum_d = SUM_INIT;
      cnt_d = '0;
      k0_d  = key[127:96];
      k1_d  = key[95:64];
      k2_d  = key[63:32];
      k3_d  = key[31:0];
    end else if (state_q == ST_ROUND) begin
      v0_d  = rnd_v0;
      v1_d  = rnd_v1;
      sum_d = sum_q - DELTA;
      cnt_d = cnt_q + 6'd1;
      if (last_round) begin
        ov0_d = rnd_v0;
        ov1_d = rnd_v1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v0_q  <= '0;
      v1_q  <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      k0_q  <= '0;
      k1_q  <= '0;
      k2_q  <= '0;
      k3_q  <= '0;
      ov0_q <= '0;
      ov1_q <= '0;
    end else begin
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      k0_q  <= k0_d;
      k1_q  <= k1_d;
      k2_q  <= k2_d;
      k3_q  <= k3_d;
      ov0_q <= ov0_d;
      ov1_q <= ov1_d;
    end
  end

  assign out_v0 = ov0_q;
  assign out_v1 = ov1_q;

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Directed and randomized bench for tea_decrypt_core: plaintexts are enciphered
// by a software TEA model and the core must return the original block.
module tb_tea_decrypt_core;
  import tea_pkg::*;

  localparam int unsigned ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_v0 = '0;
  logic [31:0]  in_v1 = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_v0;
  logic [31:0]  out_v1;
  logic         busy;
  tea_state_e   dbg_state;

  logic [63:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tea_decrypt_core dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_v0       (in_v0),
    .in_v1       (in_v1),
    .key         (key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_v0      (out_v0),
    .out_v1      (out_v1),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference TEA encipher, written from the algorithm definition.
  function automatic logic [63:0] tea_enc(input logic [31:0] p0, input logic [31:0] p1,
                                          input logic [127:0] k);
    logic [31:0] v0, v1, s, k0, k1, k2, k3;
    v0 = p0; v1 = p1; s = 32'd0;
    k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
    for (int i = 0; i < int'(ROUNDS); i++) begin
      s  = s + DELTA;
      v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
      v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
    end
    return {v0, v1};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block and hold it until the core accepts it; returns just after the accept edge.
  task automatic accept_block(input logic [31:0] c0, input logic [31:0] c1, input logic [127:0] k);
    int n;
    in_v0 = c0; in_v1 = c1; key = k; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("accept_timeout", 96'(in_ready), 96'(1));
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge to out_valid, optionally scrambling the key meanwhile.
  task automatic wait_result(input bit scramble_key, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (scramble_key) key = ~key ^ {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      lat++;
    end
    if (lat >= 200) check("output_timeout", 96'(out_valid), 96'(1));
  endtask

  task automatic pop_check(input string tag, output logic [63:0] e);
    check("sb_nonempty", 96'(exp_q.size() != 0), 96'(1));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    check(tag, 96'({out_v0, out_v1}), 96'(e));
  endtask

  task automatic run_block(input string tag, input logic [63:0] pt, input logic [127:0] k,
                           input bit scramble_key);
    logic [63:0] ct;
    logic [63:0] e;
    int lat;
    ct = tea_enc(pt[63:32], pt[31:0], k);
    exp_q.push_back(pt);
    accept_block(ct[63:32], ct[31:0], k);
    wait_result(scramble_key, lat);
    check({tag, "_latency"}, 96'(lat), 96'(ROUNDS));
    pop_check(tag, e);
    tick();
  endtask

  initial begin
    logic [63:0]  e;
    logic [63:0]  pt;
    logic [127:0] k;
    logic [63:0]  blk_pt[6];
    logic [127:0] blk_k[6];
    logic [63:0]  blk_ct;
    int lat, accepts, outs, cyc, last_acc, seen;
    bit acc_now;

    // Reset state
    resetn = 1'b0;
    repeat (3) tick();
    check("reset_state", 96'({in_ready, out_valid, busy, dbg_state, out_v0, out_v1}),
          96'({1'b0, 1'b0, 1'b0, ST_IDLE, 64'd0}));
    resetn = 1'b1;
    tick();
    check("ready_after_reset", 96'({in_ready, dbg_state}), 96'({1'b1, ST_IDLE}));

    // Known vector: all-zero plaintext and key
    exp_q.push_back(64'd0);
    accept_block(32'h41EA3A0A, 32'h94BAA940, 128'd0);
    check("busy_in_round", 96'({busy, in_ready, out_valid, dbg_state}),
          96'({1'b1, 1'b0, 1'b0, ST_ROUND}));
    wait_result(1'b0, lat);
    check("vector_latency", 96'(lat), 96'(32));
    pop_check("vector_zero", e);
    tick();
    check("idle_after_output", 96'({in_ready, out_valid, busy}), 96'({1'b1, 1'b0, 1'b0}));

    // Random round trips
    for (int i = 0; i < 1000; i++) begin
      pt = {$urandom(), $urandom()};
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block("roundtrip", pt, k, 1'b0);
    end

    // Downstream stall: outputs held, new input ignored
    out_ready = 1'b0;
    pt = {$urandom(), $urandom()};
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    blk_ct = tea_enc(pt[63:32], pt[31:0], k);
    exp_q.push_back(pt);
    accept_block(blk_ct[63:32], blk_ct[31:0], k);
    wait_result(1'b0, lat);
    pop_check("stall_first", e);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_v0 = $urandom(); in_v1 = $urandom();
      tick();
      check("stall_hold", 96'({out_valid, in_ready, busy, dbg_state, out_v0, out_v1}),
            96'({1'b1, 1'b0, 1'b1, ST_DONE, pt}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release", 96'({in_ready, out_valid, busy, dbg_state, out_v0, out_v1}),
          96'({1'b1, 1'b0, 1'b0, ST_IDLE, pt}));

    // Key scrambled every cycle during the rounds
    for (int i = 0; i < 3; i++) begin
      pt = {$urandom(), $urandom()};
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block("key_scramble", pt, k, 1'b1);
    end

    // Reset at round 10 aborts the block
    pt = {$urandom(), $urandom()};
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    blk_ct = tea_enc(pt[63:32], pt[31:0], k);
    accept_block(blk_ct[63:32], blk_ct[31:0], k);
    repeat (10) tick();
    resetn = 1'b0;
    tick();
    check("abort_reset_state", 96'({in_ready, out_valid, busy, dbg_state, out_v0, out_v1}),
          96'({1'b0, 1'b0, 1'b0, ST_IDLE, 64'd0}));
    resetn = 1'b1;
    #1;
    check("abort_ready", 96'(in_ready), 96'(1));
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_output", 96'(seen), 96'(0));
    pt = {$urandom(), $urandom()};
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_block("after_abort", pt, k, 1'b0);

    // in_valid held high continuously: one accept per ROUNDS+2 cycles
    for (int i = 0; i < 6; i++) begin
      blk_pt[i] = {$urandom(), $urandom()};
      blk_k[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    accepts = 0; outs = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1;
    blk_ct = tea_enc(blk_pt[0][63:32], blk_pt[0][31:0], blk_k[0]);
    in_v0 = blk_ct[63:32]; in_v1 = blk_ct[31:0]; key = blk_k[0];
    in_valid = 1'b1;
    while (outs < 5 && cyc < 600) begin
      acc_now = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(blk_pt[accepts]);
        if (last_acc >= 0) check("stream_interval", 96'(cyc - last_acc), 96'(ROUNDS + 2));
        last_acc = cyc;
        accepts++;
        acc_now = 1'b1;
      end
      if (out_valid && out_ready) begin
        pop_check("stream_data", e);
        outs++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (accepts < 6) begin
          blk_ct = tea_enc(blk_pt[accepts][63:32], blk_pt[accepts][31:0], blk_k[accepts]);
          in_v0 = blk_ct[63:32]; in_v1 = blk_ct[31:0]; key = blk_k[accepts];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("stream_outputs", 96'(outs), 96'(5));
    while (exp_q.size() != 0 && cyc < 800) begin
      wait_result(1'b0, lat);
      pop_check("stream_drain", e);
      outs++;
      tick();
      cyc += lat + 1;
    end
    check("stream_no_double_accept", 96'(accepts), 96'(outs));
    repeat (40) tick();
    check("final_idle", 96'({in_ready, out_valid, busy, dbg_state}),
          96'({1'b1, 1'b0, 1'b0, ST_IDLE}));
    check("scoreboard_empty", 96'(exp_q.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
